// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, single write-back.
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [4:0]      rd_idx_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            wr_en_o,
    output logic [4:0]      wr_idx_o,
    output logic [XLEN-1:0] wr_data_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   araw_q, araw_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              bzero_q, bzero_d;
    logic              ovf_q, ovf_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;

    logic              accept;
    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_in;
    logic              ovf_in;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   result;

    assign accept = (state_q == S_IDLE) && start_i;

    // Operand decode: signedness, magnitudes, result sign and overflow case
    always_comb begin
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        neg_in = 1'b0;
        ovf_in = 1'b0;
        unique case (funct3_i)
            3'b001, 3'b100, 3'b110: begin
                sgn_a = rs1_val_i[XLEN-1];
                sgn_b = rs2_val_i[XLEN-1];
            end
            3'b010: sgn_a = rs1_val_i[XLEN-1];
            default: ;
        endcase
        mag_a = sgn_a ? -rs1_val_i : rs1_val_i;
        mag_b = sgn_b ? -rs2_val_i : rs2_val_i;
        if (funct3_i[2] && funct3_i[1])
            neg_in = sgn_a;
        else
            neg_in = sgn_a ^ sgn_b;
        ovf_in = funct3_i[2] && !funct3_i[0]
              && (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}})
              && (rs2_val_i == {XLEN{1'b1}});
    end

    // One multiply step (LSB-first) and one restoring divide step (MSB-first)
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + {1'b0, (b_q[0] ? a_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, b_q};
        qbit     = ~div_diff[XLEN];
        rem_new  = qbit ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_next = {rem_new, acc_q[XLEN-2:0], qbit};
    end

    // Datapath next-state: latch on accept, iterate in CALC
    always_comb begin
        f3_d    = f3_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        araw_d  = araw_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bzero_d = bzero_q;
        ovf_d   = ovf_q;
        if (accept) begin
            f3_d    = funct3_i;
            rd_d    = rd_idx_i;
            a_d     = mag_a;
            b_d     = mag_b;
            araw_d  = rs1_val_i;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = neg_in;
            bzero_d = (rs2_val_i == '0);
            ovf_d   = ovf_in;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + CW'(1);
            if (f3_q[2]) begin
                acc_d = div_next;
                a_d   = {a_q[XLEN-2:0], 1'b0};
            end else begin
                acc_d = mul_next;
                b_d   = {1'b0, b_q[XLEN-1:1]};
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_CALC;
            S_CALC: if (cnt_q == CW'(XLEN-1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Final result selection with sign and special-case overrides
    always_comb begin
        prod  = neg_q ? -acc_q : acc_q;
        quo_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (f3_q)
            3'b000:
                result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011:
                result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:
                result = bzero_q ? {XLEN{1'b1}} : (ovf_q ? araw_q : quo_s);
            default:
                result = bzero_q ? araw_q : (ovf_q ? {XLEN{1'b0}} : rem_s);
        endcase
    end

    // Output logic, registered one cycle behind the state
    always_comb begin
        busy_d    = (state_q != S_IDLE);
        done_d    = (state_q == S_DONE);
        wr_en_d   = done_d && (rd_q != 5'd0);
        wr_data_d = done_d ? result : {XLEN{1'b0}};
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f3_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            araw_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            bzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            araw_q    <= araw_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            bzero_q   <= bzero_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign wr_en_o   = wr_en_q;
    assign wr_idx_o  = rd_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: scoreboard bench for the RV32M multiply/divide unit.
// Expected write-backs are queued at issue and popped on each done pulse.
module tb_riscv_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_idx;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;

    typedef struct {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    riscv_muldiv #(.XLEN(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .funct3_i  (funct3),
        .rs1_val_i (rs1_val),
        .rs2_val_i (rs2_val),
        .rd_idx_i  (rd_idx),
        .busy_o    (busy),
        .done_o    (done),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] as_, bs;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        as_ = a;
        bs  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return as_ / bs;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return as_ % bs;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Issue one op, watch 40 cycles, compare the write-back against the queue.
    // dup_at > 1 fires a second, different start while the unit is busy.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] expv, input int dup_at,
                         input string nm);
        exp_t e;
        exp_t got;
        int   dcnt;
        int   dcyc;
        e.en   = (rd != 5'd0);
        e.idx  = rd;
        e.data = expv;
        sb_q.push_back(e);
        @(negedge clk);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_idx  = rd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_idx  = 5'd31;
        dcnt = 0;
        dcyc = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == dup_at) begin
                funct3  = ~f;
                rs1_val = 32'h1111_2222;
                rs2_val = 32'h0000_0003;
                rd_idx  = 5'd17;
                start   = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_c1 got=%b exp=1", nm, busy);
                end
            end
            if (k == 34) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_c34 got=%b exp=0", nm, busy);
                end
            end
            if (done === 1'b1) begin
                dcnt++;
                if (dcyc < 0) dcyc = k;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_done cycle=%0d", nm, k);
                end else begin
                    got = sb_q.pop_front();
                    if (wr_en !== got.en || wr_idx !== got.idx
                        || wr_data !== got.data) begin
                        failures++;
                        $display("FAIL %s wb got en=%b idx=%0d data=%h exp en=%b idx=%0d data=%h",
                                 nm, wr_en, wr_idx, wr_data,
                                 got.en, got.idx, got.data);
                    end
                end
            end
        end
        checks++;
        if (dcyc != 33) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=33", nm, dcyc);
        end
        checks++;
        if (dcnt != 1) begin
            failures++;
            $display("FAIL %s done_count got=%0d exp=1", nm, dcnt);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = '0;
        rs2_val = '0;
        rd_idx  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, wr_en, wr_idx, wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b en=%b idx=%0d data=%h exp all 0",
                     busy, done, wr_en, wr_idx, wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, "mul");
    endtask

    task automatic test_mulh();
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 0, "mulhu");
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 0, "mulh");
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0, "mulhsu");
    endtask

    task automatic test_div();
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0, "div_neg");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 0, "rem_neg");
        do_op(3'b101, 32'd7, 32'd2, 5'd8, 32'd3, 0, "divu");
        do_op(3'b111, 32'd7, 32'd2, 5'd8, 32'd1, 0, "remu");
    endtask

    task automatic test_special();
        do_op(3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, "divu_by0");
        do_op(3'b111, 32'd5, 32'd0, 5'd9, 32'd5, 0, "remu_by0");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0, "div_ovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 0, "rem_ovf");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd11, 32'hFFFF_FFF9, 0, "rem_by0");
    endtask

    task automatic test_rd_zero();
        do_op(3'b000, 32'd2, 32'd3, 5'd0, 32'd6, 0, "rd_zero");
    endtask

    task automatic test_busy_start();
        do_op(3'b000, 32'h1234, 32'h10, 5'd7, 32'h12340, 10, "busy_start");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        int   dc[$];
        e.en = 1'b1; e.idx = 5'd3; e.data = 32'd3;
        sb_q.push_back(e);
        e.en = 1'b1; e.idx = 5'd4; e.data = 32'd1;
        sb_q.push_back(e);
        @(negedge clk);
        funct3 = 3'b101; rs1_val = 32'd7; rs2_val = 32'd2; rd_idx = 5'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                dc.push_back(k);
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b unexpected_done cycle=%0d", k);
                end else begin
                    got = sb_q.pop_front();
                    if (wr_en !== got.en || wr_idx !== got.idx
                        || wr_data !== got.data) begin
                        failures++;
                        $display("FAIL b2b wb got idx=%0d data=%h exp idx=%0d data=%h",
                                 wr_idx, wr_data, got.idx, got.data);
                    end
                end
            end
            if (k == 33) begin
                funct3 = 3'b111; rs1_val = 32'd7; rs2_val = 32'd2; rd_idx = 5'd4;
                start = 1'b1;
            end
        end
        checks++;
        if (dc.size() != 2 || dc[0] != 33 || dc[1] != 67) begin
            failures++;
            $display("FAIL b2b done_cycles got n=%0d exp 33,67", dc.size());
        end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        @(negedge clk);
        funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd7; rd_idx = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, wr_en, wr_idx, wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b en=%b idx=%0d data=%h exp all 0",
                     busy, done, wr_en, wr_idx, wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            failures++;
            $display("FAIL reset_mid_done got=%0d exp=0", dcnt);
        end
        do_op(3'b000, 32'd3, 32'd4, 5'd6, 32'd12, 0, "mul_after_rst");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            f = 3'(i);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 6) a = -32'd1000;
            do_op(f, a, b, 5'($urandom_range(1, 31)), model(f, a, b), 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_rd_zero();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative RV32M multiply/divide unit for the RISC-V core. It takes the two source operands read from the register file together with the destination index, and computes all eight M-extension operations over a fixed multi-cycle latency. It then issues a single write-back (wr_en / wr_idx / wr_data) that drives the register file write port directly. While the unit is busy, the core stalls issue.

## Interface
- XLEN, 32: operand/result width; must be even and ≥ 8.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  operand A (dividend / multiplicand).
- rs2_val  in  XLEN  operand B (divisor / multiplier).
- rd_idx  in  5  destination register.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle completion pulse.
- wr_en  out  1  register-file write enable; equals done && (latched rd_idx != 0).
- wr_idx  out  5  latched rd_idx.
- wr_data  out  XLEN  result.

## Operation
- States: IDLE → CALC → DONE → IDLE.
- **IDLE + start**
  - Latch funct3 and rd_idx.
  - Latch magnitudes |A| and |B|. An operand is negated when it is treated as signed and its MSB is 1:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - All other ops: both unsigned.
  - Latch the result-sign flag:
    - MUL*: signA XOR signB.
    - DIV: signA XOR signB.
    - REM: signA.
  - Clear the 2·XLEN accumulator and set count = 0.
  - Go to CALC.
- **CALC**: one iteration per cycle, count 0..XLEN-1. After the iteration with count = XLEN-1, go to DONE.
  - Multiply: shift-add, LSB-first on the multiplier, producing the 2·XLEN product.
  - Divide: restoring, MSB-first, producing an XLEN quotient and XLEN remainder.
- **DONE**
  - done = 1 and wr_en as defined in the interface.
  - wr_data is the result with the sign applied (two's-complement negation when the sign flag is set):
    - MUL: low XLEN bits of the product.
    - MULH / MULHSU / MULHU: high XLEN bits.
    - DIV / DIVU: quotient.
    - REM / REMU: remainder.
  - Next state is IDLE.
- **Special cases**: they still take the full latency; the result is overridden in DONE.
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → A unmodified.
  - DIV with A = 100…0 and B = all ones: quotient = A; REM of the same operands = 0.
- **Inputs ignored**:
  - start while busy is ignored; no queueing.
  - Operand inputs are ignored outside the IDLE start cycle.
- **Reset (any time, including mid-CALC)**:
  - State → IDLE; busy, done, wr_en, wr_idx, wr_data → 0; accumulator and count → 0.
  - The in-flight op is discarded and no write is issued.

## Timing
- With start sampled at posedge 0:
  - busy = 1 from posedge 1 until posedge XLEN+2.
  - done / wr_en / wr_data are valid for exactly one cycle, between posedge XLEN+1 and XLEN+2.
  - For XLEN = 32: done at posedge 33, latency 33 cycles.
- Outputs are registered. The register file writes on negedge, so it captures the result at the middle of the DONE cycle.
- The earliest next start is sampled at posedge XLEN+2, when the unit is back in IDLE. Back-to-back throughput is therefore one op per XLEN+2 cycles.
- A start arriving in the same cycle as rst asserting is lost.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd = 5 → at posedge 33: done = 1, wr_en = 1, wr_idx = 5, wr_data = 0xFFFFFFEB; one-cycle pulse, busy low afterwards.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Same operands:
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 7 / 2 → 3. REMU → 1.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- rd = 0 → done pulses, wr_en stays 0. A second start while busy (at cycle 10) → ignored; exactly one done and the result of the first op.
- rst pulsed at cycle 15 of a DIV → all outputs 0 immediately (asynchronously), no done ever. A new MUL 3 × 4 started after release → 12 at its own posedge 33.
